// File: rtl/pmem_pkg.sv
// Shared constants, line/beat types and adaptor state encoding for the
// physical-memory side of the cache hierarchy.
package pmem_pkg;

  localparam int ADDR_W  = 32;
  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int BEATS   = LINE_W / BURST_W;
  localparam int OFS     = $clog2(LINE_W / 8);
  localparam int CNT_W   = $clog2(BEATS);

  typedef logic [LINE_W-1:0]  line_t;
  typedef logic [BURST_W-1:0] beat_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE
  } adaptor_state_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// Turns one 256-bit line request from the cache arbiter into a 4-beat 64-bit
// burst on the external memory port, returning a single-cycle line response.
module cacheline_adaptor
  import pmem_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               pmem_read,
  input  logic               pmem_write,
  input  logic [ADDR_W-1:0]  pmem_addr,
  input  logic [LINE_W-1:0]  pmem_wdata,
  output logic [LINE_W-1:0]  pmem_rdata,
  output logic               pmem_resp,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [BURST_W-1:0] mem_wdata,
  input  logic [BURST_W-1:0] mem_rdata,
  input  logic               mem_resp
);

  adaptor_state_e   r_state;
  logic [CNT_W-1:0] r_cnt;
  line_t            r_line;
  logic [ADDR_W-1:0] r_addr;
  logic             r_pmem_resp;
  logic             r_mem_read;
  logic             r_mem_write;
  logic             w_last_beat;

  assign w_last_beat = (r_cnt == CNT_W'(BEATS - 1));

  // One line buffer serves both directions: filled beat by beat on reads,
  // loaded whole at accept on writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_line      <= '0;
      r_addr      <= '0;
      r_pmem_resp <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else begin
      r_pmem_resp <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (pmem_read) begin
            r_addr     <= {pmem_addr[ADDR_W-1:OFS], {OFS{1'b0}}};
            r_line     <= '0;
            r_cnt      <= '0;
            r_mem_read <= 1'b1;
            r_state    <= ST_RD;
          end else if (pmem_write) begin
            r_addr      <= {pmem_addr[ADDR_W-1:OFS], {OFS{1'b0}}};
            r_line      <= pmem_wdata;
            r_cnt       <= '0;
            r_mem_write <= 1'b1;
            r_state     <= ST_WR;
          end
        end
        ST_RD: begin
          if (mem_resp) begin
            r_line[32'(r_cnt)*BURST_W +: BURST_W] <= mem_rdata;
            r_cnt <= r_cnt + 1'b1;
            if (w_last_beat) begin
              r_mem_read  <= 1'b0;
              r_pmem_resp <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end
        ST_WR: begin
          if (mem_resp) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last_beat) begin
              r_mem_write <= 1'b0;
              r_pmem_resp <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign pmem_rdata = r_line;
  assign pmem_resp  = r_pmem_resp;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_line[32'(r_cnt)*BURST_W +: BURST_W];

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: a behavioural memory responder
// drives beats with programmable stalls and checks line-level results.
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_addr;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_resp = 0;
  logic [31:0] exp_mem_addr = '0;

  cacheline_adaptor dut (
    .clk        (clk),
    .rst        (rst),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_addr  (pmem_addr),
    .pmem_wdata (pmem_wdata),
    .pmem_rdata (pmem_rdata),
    .pmem_resp  (pmem_resp),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pmem_resp === 1'b1) n_resp <= n_resp + 1;
  end

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Cycles from the accept edge to pmem_resp: one per memory-side cycle until
  // four beats have been granted, plus the DONE cycle.
  function automatic int expected_latency(input logic [31:0] pat);
    int ones = 0;
    int t = 0;
    while (ones < 4) begin
      if (t >= 32 || pat[t]) ones++;
      t++;
    end
    return t + 1;
  endfunction

  // One full line transaction. Called in an IDLE cycle (#1 after an edge);
  // returns in the IDLE cycle after DONE. pat[i] is mem_resp for the i-th
  // burst cycle (1 beyond bit 31).
  task automatic txn(input bit rd, input logic [31:0] addr, input logic [255:0] line,
                     input logic [31:0] pat, input bit scramble, input bit hold_other,
                     input string name, output int first_cyc);
    int t = 0;
    int k = 0;
    int act = 0;
    int nresp_burst = 0;
    bit done = 0;
    logic [31:0] exp_addr;
    int exp_lat;
    exp_addr  = {addr[31:5], 5'b0};
    exp_lat   = expected_latency(pat);
    first_cyc = -1;
    pmem_addr = addr;
    if (rd) begin
      pmem_read  = 1'b1;
      pmem_write = hold_other;
      if (!hold_other) pmem_wdata = rand_line();
    end else begin
      pmem_write = 1'b1;
      pmem_read  = 1'b0;
      pmem_wdata = line;
    end
    while (!done && t < 100) begin
      @(posedge clk); #1; t++;
      mem_resp = 1'b0;
      if (scramble) begin
        pmem_addr  = $urandom;
        pmem_wdata = rand_line();
      end
      if (pmem_resp) begin
        done = 1;
        checks++;
        if (t !== exp_lat || k !== 4 || nresp_burst !== 4) begin
          errors++;
          $display("FAIL %s_latency got t=%0d beats=%0d expected t=%0d beats=4", name, t, k, exp_lat);
        end
        checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
          errors++;
          $display("FAIL %s_done_idle got rd=%b wr=%b expected 0 0", name, mem_read, mem_write);
        end
        if (rd) begin
          checks++;
          if (pmem_rdata !== line) begin
            errors++;
            $display("FAIL %s_rdata got %h expected %h", name, pmem_rdata, line);
          end
        end
        if (rd) pmem_read = 1'b0;
        else pmem_write = 1'b0;
      end else if (mem_read || mem_write) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (mem_read !== rd || mem_write !== !rd || mem_addr !== exp_addr) begin
          checks++;
          errors++;
          $display("FAIL %s_burst got rd=%b wr=%b addr=%h expected rd=%b wr=%b addr=%h",
                   name, mem_read, mem_write, mem_addr, rd, !rd, exp_addr);
        end
        if (!rd && k < 4 && mem_wdata !== line[k*64 +: 64]) begin
          checks++;
          errors++;
          $display("FAIL %s_wdata beat %0d got %h expected %h", name, k, mem_wdata, line[k*64 +: 64]);
        end
        mem_resp = (act >= 32) ? 1'b1 : pat[act];
        act++;
        if (mem_resp) begin
          if (rd && k < 4) mem_rdata = line[k*64 +: 64];
          else mem_rdata = {$urandom, $urandom};
          k++;
          nresp_burst++;
        end
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout got no pmem_resp expected one within 100 cycles", name);
    end
    exp_mem_addr = exp_addr;
    @(posedge clk); #1;
    checks++;
    if (pmem_resp !== 1'b0) begin
      errors++;
      $display("FAIL %s_resp_width got pmem_resp=%b expected 0 after one cycle", name, pmem_resp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pmem_read = 0; pmem_write = 0; pmem_addr = '0; pmem_wdata = '0;
    mem_rdata = '0; mem_resp = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({pmem_resp, mem_read, mem_write} !== 3'b000 || mem_addr !== 32'h0 || pmem_rdata !== '0) begin
      errors++;
      $display("FAIL reset_state got resp=%b rd=%b wr=%b addr=%h rdata=%h expected all zero",
               pmem_resp, mem_read, mem_write, mem_addr, pmem_rdata);
    end
  endtask

  task automatic test_read_nostall();
    int fc;
    txn(1, 32'h0000_1234, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
        32'hFFFF_FFFF, 1, 0, "read_nostall", fc);
  endtask

  task automatic test_write_stalls();
    int fc;
    int r0;
    r0 = n_resp;
    txn(0, 32'h8000_00E0, {64'hDDDD_0003_DDDD_0003, 64'hCCCC_0002_CCCC_0002,
                           64'hBBBB_0001_BBBB_0001, 64'hAAAA_0000_AAAA_0000},
        32'hFFFF_FFD9, 1, 0, "write_stalls", fc);
    checks++;
    if (n_resp - r0 !== 1) begin
      errors++;
      $display("FAIL write_stalls_resp_count got %0d expected 1", n_resp - r0);
    end
  endtask

  task automatic test_simultaneous();
    int fc;
    logic [255:0] rl, wl;
    int r0;
    rl = rand_line();
    wl = rand_line();
    r0 = n_resp;
    pmem_wdata = wl;
    txn(1, 32'h0000_5A40, rl, 32'hFFFF_FFFF, 0, 1, "simul_read", fc);
    txn(0, 32'h0000_5A40, wl, 32'hFFFF_FFFF, 0, 0, "simul_write", fc);
    checks++;
    if (n_resp - r0 !== 2) begin
      errors++;
      $display("FAIL simul_resp_count got %0d expected 2", n_resp - r0);
    end
  endtask

  task automatic test_back_to_back();
    int fc1, fc2, r0;
    r0 = n_resp;
    txn(1, 32'h0000_0100, rand_line(), 32'hFFFF_FFFF, 1, 0, "b2b_icache", fc1);
    txn(1, 32'h0000_0200, rand_line(), 32'hFFFF_FFFF, 1, 0, "b2b_dcache", fc2);
    checks++;
    if (fc2 - fc1 !== 6 || n_resp - r0 !== 2) begin
      errors++;
      $display("FAIL b2b_spacing got spacing=%0d resps=%0d expected spacing=6 resps=2",
               fc2 - fc1, n_resp - r0);
    end
  endtask

  task automatic test_reset_midburst();
    int beats = 0;
    int t = 0;
    int r0;
    int fc;
    r0 = n_resp;
    pmem_read = 1'b1;
    pmem_addr = 32'h0000_0440;
    while (beats < 3 && t < 50) begin
      @(posedge clk); #1; t++;
      mem_resp = 1'b0;
      if (mem_read) begin
        mem_resp  = 1'b1;
        mem_rdata = {$urandom, $urandom};
        beats++;
      end
    end
    checks++;
    if (beats !== 3) begin
      errors++;
      $display("FAIL rst_mid_setup got %0d beats expected 3", beats);
    end
    @(posedge clk); #1;
    mem_resp = 1'b0;
    rst = 1'b1;
    pmem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (mem_read !== 1'b0 || pmem_resp !== 1'b0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_abort got rd=%b resp=%b addr=%h expected 0 0 0", mem_read, pmem_resp, mem_addr);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (n_resp !== r0 || mem_read !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_no_resp got resps=%0d rd=%b expected %0d 0", n_resp - r0, mem_read, 0);
    end
    exp_mem_addr = '0;
    txn(1, 32'h0000_0460, rand_line(), 32'hFFFF_FFFF, 1, 0, "rst_mid_after", fc);
  endtask

  task automatic test_spurious();
    int r0;
    r0 = n_resp;
    for (int i = 0; i < 4; i++) begin
      mem_resp  = 1'b1;
      pmem_addr = $urandom;
      @(posedge clk); #1;
      checks++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0 || pmem_resp !== 1'b0 || mem_addr !== exp_mem_addr) begin
        errors++;
        $display("FAIL spurious_idle got rd=%b wr=%b resp=%b addr=%h expected 0 0 0 %h",
                 mem_read, mem_write, pmem_resp, mem_addr, exp_mem_addr);
      end
    end
    mem_resp = 1'b0;
    checks++;
    if (n_resp !== r0) begin
      errors++;
      $display("FAIL spurious_resp got %0d pulses expected 0", n_resp - r0);
    end
  endtask

  task automatic test_random();
    int fc;
    for (int i = 0; i < 10; i++) begin
      bit rd;
      logic [31:0] pat;
      rd  = $urandom_range(0, 1);
      pat = $urandom | 32'h0000_0001;
      txn(rd, $urandom, rand_line(), pat, 1, 0, "random", fc);
    end
  endtask

  initial begin
    test_reset();
    test_read_nostall();
    test_write_stalls();
    test_simultaneous();
    test_back_to_back();
    test_reset_midburst();
    test_spurious();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
